// File: rtl/dbus_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_sram_slave
//  Description : Single-port SRAM slave on the CPU data bus. It accepts
//                single-word byte-masked writes and serves reads as 1..8
//                beat bursts, with one beat per cycle. Out-of-range read
//                beats carry the error flag.
//                Optional macro DBUS_SLAVE_STALL_EN adds random LFSR stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module dbus_sram_slave #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned MAX_SIZE  = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dBus_cmd_valid,
    output logic        dBus_cmd_ready,
    input  logic        dBus_cmd_payload_wr,
    input  logic        dBus_cmd_payload_uncached,
    input  logic [31:0] dBus_cmd_payload_address,
    input  logic [31:0] dBus_cmd_payload_data,
    input  logic [3:0]  dBus_cmd_payload_mask,
    input  logic [2:0]  dBus_cmd_payload_size,
    input  logic        dBus_cmd_payload_last,
    output logic        dBus_rsp_valid,
    output logic        dBus_rsp_payload_last,
    output logic [31:0] dBus_rsp_payload_data,
    output logic        dBus_rsp_payload_error
);

    localparam int unsigned c_aw    = $clog2(MEM_WORDS);
    localparam logic [29:0] c_depth = 30'(MEM_WORDS);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t      state_q;
    logic        ready_q;
    logic        valid_q;
    logic        last_q;
    logic [31:0] data_q;
    logic        err_q;
    logic [29:0] base_word_q;
    logic [3:0]  last_k_q;
    logic [3:0]  k_q;
    logic [31:0] mem_q [MEM_WORDS];

    logic        w_stall_ready;
    logic        w_stall_beat;

    // ---------------------------------------------------------------- decode
    logic [2:0]  w_size;
    logic [3:0]  w_last_k;
    logic [31:0] w_base;
    logic        w_fire;
    logic        w_rd_fire;
    logic        w_wr_fire;
    logic        w_wr_oor;

    assign w_size    = (dBus_cmd_payload_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE)
                                                              : dBus_cmd_payload_size;
    // Beats minus one; sizes below a word still return one full word.
    assign w_last_k  = (w_size < 3'd2) ? 4'd0
                                       : 4'((6'd1 << (w_size - 3'd2)) - 6'd1);
    assign w_base    = dBus_cmd_payload_address & ~((32'd1 << w_size) - 32'd1);
    assign w_fire    = (state_q == S_IDLE) && dBus_cmd_valid && ready_q;
    assign w_rd_fire = w_fire && !dBus_cmd_payload_wr;
    assign w_wr_fire = w_fire && dBus_cmd_payload_wr;
    assign w_wr_oor  = (dBus_cmd_payload_address[31:2] >= c_depth);

    // ------------------------------------------------------- beat selection
    // On the accepting edge the beat comes straight from the command; later
    // beats come from the latched burst context.
    logic        w_idle;
    logic [29:0] w_cur_base;
    logic [3:0]  w_cur_k;
    logic [3:0]  w_cur_last_k;
    logic [29:0] w_idx;
    logic        w_oor;
    logic [31:0] w_rd_data;
    logic        w_step;

    assign w_idle       = (state_q == S_IDLE);
    assign w_cur_base   = w_idle ? w_base[31:2] : base_word_q;
    assign w_cur_k      = w_idle ? 4'd0 : k_q;
    assign w_cur_last_k = w_idle ? w_last_k : last_k_q;
    assign w_idx        = w_cur_base + {26'd0, w_cur_k};
    assign w_oor        = (w_idx >= c_depth);
    assign w_rd_data    = mem_q[w_idx[c_aw-1:0]];
    assign w_step       = w_idle ? w_rd_fire : !(valid_q && last_q);

    logic w_unused;
    assign w_unused = ^{dBus_cmd_payload_uncached, dBus_cmd_payload_last, w_base[1:0]};

`ifdef DBUS_SLAVE_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci taps 16,14,13,11; decisions use the value visible next cycle
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign w_stall_ready = lfsr_d[0];
    assign w_stall_beat  = lfsr_d[1];

    // Free-running stall LFSR
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign w_stall_ready = 1'b0;
    assign w_stall_beat  = 1'b0;
`endif

    // Byte-masked write into the array; memory contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_fire && !w_wr_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (dBus_cmd_payload_mask[i]) begin
                    mem_q[dBus_cmd_payload_address[c_aw+1:2]][8*i +: 8] <=
                        dBus_cmd_payload_data[8*i +: 8];
                end
            end
        end
    end

    // Command acceptance, burst sequencing and registered response beats
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= 32'd0;
            err_q       <= 1'b0;
            base_word_q <= 30'd0;
            last_k_q    <= 4'd0;
            k_q         <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_rd_fire) begin
                        state_q     <= S_BURST;
                        ready_q     <= 1'b0;
                        base_word_q <= w_base[31:2];
                        last_k_q    <= w_last_k;
                    end else begin
                        ready_q <= !w_stall_ready;
                    end
                end
                S_BURST: begin
                    // Last beat was on the bus this cycle: close the burst
                    if (valid_q && last_q) begin
                        state_q <= S_IDLE;
                        ready_q <= !w_stall_ready;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase

            if (w_step) begin
                if (w_stall_beat) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    k_q     <= w_cur_k;
                end else begin
                    valid_q <= 1'b1;
                    last_q  <= (w_cur_k == w_cur_last_k);
                    err_q   <= w_oor;
                    data_q  <= w_oor ? 32'd0 : w_rd_data;
                    // Counter saturates at the final beat index
                    k_q     <= (w_cur_k == w_cur_last_k) ? w_cur_k : 4'(w_cur_k + 4'd1);
                end
            end
        end
    end

    assign dBus_cmd_ready         = ready_q;
    assign dBus_rsp_valid         = valid_q;
    assign dBus_rsp_payload_last  = last_q;
    assign dBus_rsp_payload_data  = data_q;
    assign dBus_rsp_payload_error = err_q;

endmodule
`default_nettype wire
